// File: rtl/spell_seq_pkg.sv
// Shared definitions for the SPELL pin sequencer: FSM state encoding and the
// layout of one stimulus entry {rst_n, check, hold, mask, exp, uio, ui}.
package spell_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_APPLY = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Width of one stimulus entry.
    function automatic int entry_w(input int io_w, input int hold_w);
        return 4 * io_w + hold_w + 2;
    endfunction

    // Field offsets inside a stimulus entry, LSB first.
    function automatic int off_ui(input int io_w);
        return 0 * io_w;
    endfunction

    function automatic int off_uio(input int io_w);
        return 1 * io_w;
    endfunction

    function automatic int off_exp(input int io_w);
        return 2 * io_w;
    endfunction

    function automatic int off_mask(input int io_w);
        return 3 * io_w;
    endfunction

    function automatic int off_hold(input int io_w);
        return 4 * io_w;
    endfunction

    function automatic int off_check(input int io_w, input int hold_w);
        return 4 * io_w + hold_w;
    endfunction

    function automatic int off_rst(input int io_w, input int hold_w);
        return 4 * io_w + hold_w + 1;
    endfunction

endpackage

// File: rtl/spell_seq_mem.sv
// Generic single-write, single-read synchronous RAM. Read data is registered;
// a write and a read of the same address in one cycle return the old data.
module spell_seq_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array: written on request, never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; only the output register is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spell_pin_sequencer.sv
// Pin-level replay harness for the SPELL user project. Plays a stored stimulus
// program onto the DUT pins, holds each step hold+1 cycles, compares uo_out to
// masked expectations on the last cycle of each step and records captures.
//
// Control protocol: start is a single-cycle pulse honoured only while not busy
// and only when abort is low in the same cycle; prog_we is honoured only while
// not busy, so the program is frozen for the duration of a run.
module spell_pin_sequencer
    import spell_seq_pkg::*;
#(
    parameter int IO_W   = 8,
    parameter int DEPTH  = 64,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 8,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int E_W    = entry_w(IO_W, HOLD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [E_W-1:0]    prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [ADDR_W-1:0] first_fail,
    input  logic [ADDR_W-1:0] cap_addr,
    output logic [IO_W-1:0]   cap_data,
    output logic [IO_W-1:0]   dut_ui_in,
    output logic [IO_W-1:0]   dut_uio_in,
    output logic              dut_rst_n,
    output logic              dut_ena,
    input  logic [IO_W-1:0]   dut_uo_out,
    input  logic [IO_W-1:0]   dut_uio_out,
    input  logic [IO_W-1:0]   dut_uio_oe
);

    localparam int OFF_UI    = off_ui(IO_W);
    localparam int OFF_UIO   = off_uio(IO_W);
    localparam int OFF_EXP   = off_exp(IO_W);
    localparam int OFF_MASK  = off_mask(IO_W);
    localparam int OFF_HOLD  = off_hold(IO_W);
    localparam int OFF_CHECK = off_check(IO_W, HOLD_W);
    localparam int OFF_RST   = off_rst(IO_W, HOLD_W);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   idx, idx_d;
    logic [ADDR_W:0]     len_q;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [E_W-1:0]      rd_entry;

    logic [IO_W-1:0]     e_ui, e_uio, e_exp, e_mask;
    logic [HOLD_W-1:0]   e_hold;
    logic                e_check, e_rst_n;

    logic                start_ok, run_go, run_empty;
    logic                in_step, step_end, last_step, fail_now;
    logic                stim_we;

    // The driven-uio view is not recorded; the capture holds uo_out only.
    logic [IO_W-1:0]     uio_driven;
    logic                unused_uio;
    assign uio_driven = dut_uio_out & dut_uio_oe;
    assign unused_uio = ^uio_driven;

    assign e_ui    = rd_entry[OFF_UI   +: IO_W];
    assign e_uio   = rd_entry[OFF_UIO  +: IO_W];
    assign e_exp   = rd_entry[OFF_EXP  +: IO_W];
    assign e_mask  = rd_entry[OFF_MASK +: IO_W];
    assign e_hold  = rd_entry[OFF_HOLD +: HOLD_W];
    assign e_check = rd_entry[OFF_CHECK];
    assign e_rst_n = rd_entry[OFF_RST];

    assign busy    = (state == S_FETCH) || (state == S_APPLY) || (state == S_HOLD);
    assign stim_we = prog_we && !busy;

    // Stimulus program store; read address is the next index so the entry is
    // already on rd_entry during FETCH.
    spell_seq_mem #(.WIDTH(E_W), .DEPTH(DEPTH)) u_stim_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (stim_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (idx_d),
        .rdata (rd_entry)
    );

    // Capture store: one uo_out sample per executed step.
    spell_seq_mem #(.WIDTH(IO_W), .DEPTH(DEPTH)) u_cap_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (step_end),
        .waddr (idx),
        .wdata (dut_uo_out),
        .raddr (cap_addr),
        .rdata (cap_data)
    );

    // Run-control strobes and the per-step compare.
    always_comb begin
        start_ok  = start && !abort && ((state == S_IDLE) || (state == S_DONE));
        run_go    = start_ok && (prog_len != '0);
        run_empty = start_ok && (prog_len == '0);
        in_step   = (state == S_APPLY) || (state == S_HOLD);
        last_step = (({1'b0, idx}) + (ADDR_W + 1)'(1)) == len_q;
        step_end  = in_step && !abort && (hold_cnt == '0);
        fail_now  = step_end && e_check && (((dut_uo_out ^ e_exp) & e_mask) != '0);
    end

    // Next-state and next-index logic.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        case (state)
            S_IDLE, S_DONE: begin
                if (run_go) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end else if (run_empty) begin
                    state_d = S_DONE;
                end
            end
            S_FETCH: begin
                state_d = abort ? S_DONE : S_APPLY;
            end
            S_APPLY, S_HOLD: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (hold_cnt == '0) begin
                    if (last_step) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        idx_d   = idx + ADDR_W'(1);
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and step index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    // Pins, hold counter, result flags and mismatch bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            hold_cnt     <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            dut_ui_in    <= '0;
            dut_uio_in   <= '0;
            dut_rst_n    <= 1'b0;
            dut_ena      <= 1'b0;
        end else begin
            if (run_go || run_empty) begin
                mismatch_cnt <= '0;
                first_fail   <= '0;
                done         <= run_empty;
                pass         <= run_empty;
            end
            if (run_go) begin
                len_q   <= prog_len;
                dut_ena <= 1'b1;
            end
            if ((state == S_FETCH) && !abort) begin
                dut_ui_in  <= e_ui;
                dut_uio_in <= e_uio;
                dut_rst_n  <= e_rst_n;
                hold_cnt   <= e_hold;
            end
            if (in_step && !abort && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            if (fail_now) begin
                if (mismatch_cnt != {CNT_W{1'b1}}) begin
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
                if (mismatch_cnt == '0) begin
                    first_fail <= idx;
                end
            end
            if (step_end && last_step) begin
                done      <= 1'b1;
                pass      <= (mismatch_cnt == '0) && !fail_now;
                dut_ena   <= 1'b0;
                dut_rst_n <= 1'b0;
            end
            if (abort && busy) begin
                done      <= 1'b1;
                pass      <= 1'b0;
                dut_ena   <= 1'b0;
                dut_rst_n <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spell_pin_sequencer.sv
// Bench for spell_pin_sequencer. The modelled DUT drives
// uo_out = ui_in ^ uio_in ^ uo_xor, where uo_xor is a bench-controlled disturbance.
module tb_spell_pin_sequencer;

    localparam int IO_W   = 8;
    localparam int DEPTH  = 512;
    localparam int HOLD_W = 8;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 9;
    localparam int E_W    = 4 * IO_W + HOLD_W + 2;

    logic              clk;
    logic              rst_n;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [E_W-1:0]    prog_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [ADDR_W-1:0] first_fail;
    logic [ADDR_W-1:0] cap_addr;
    logic [IO_W-1:0]   cap_data;
    logic [IO_W-1:0]   dut_ui_in;
    logic [IO_W-1:0]   dut_uio_in;
    logic              dut_rst_n;
    logic              dut_ena;
    logic [IO_W-1:0]   dut_uo_out;
    logic [IO_W-1:0]   dut_uio_out;
    logic [IO_W-1:0]   dut_uio_oe;
    logic [IO_W-1:0]   uo_xor;

    int n_cmp = 0;
    int n_bad = 0;

    logic [IO_W-1:0] exp_q[$];

    spell_pin_sequencer #(
        .IO_W(IO_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
        .first_fail(first_fail), .cap_addr(cap_addr), .cap_data(cap_data),
        .dut_ui_in(dut_ui_in), .dut_uio_in(dut_uio_in), .dut_rst_n(dut_rst_n),
        .dut_ena(dut_ena), .dut_uo_out(dut_uo_out), .dut_uio_out(dut_uio_out),
        .dut_uio_oe(dut_uio_oe)
    );

    assign dut_uo_out  = dut_ui_in ^ dut_uio_in ^ uo_xor;
    assign dut_uio_out = 8'h5A;
    assign dut_uio_oe  = 8'hF0;

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver and checker helpers.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [E_W-1:0] mk_entry(input logic r, input logic c,
        input logic [7:0] h, input logic [7:0] m, input logic [7:0] e,
        input logic [7:0] uio, input logic [7:0] ui);
        return {r, c, h, m, e, uio, ui};
    endfunction

    task automatic load(input int a, input logic [E_W-1:0] e);
        prog_we   = 1'b1;
        prog_addr = a[ADDR_W-1:0];
        prog_data = e;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic launch(input int len);
        start    = 1'b1;
        prog_len = len[ADDR_W:0];
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20000) begin
            tick();
            cyc++;
        end
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic read_cap(input int a, output logic [7:0] v);
        cap_addr = a[ADDR_W-1:0];
        tick();
        v = cap_data;
    endtask

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uio;
        logic [7:0] xr;
        logic [7:0] ex;
        logic [7:0] mask;
        logic [7:0] hold;
        logic       chk_en;
        logic       exp_pass;
        logic [7:0] exp_cnt;
        logic [7:0] exp_cap;
    } vec_t;

    vec_t vt[7];

    initial begin
        int cyc;
        int k;
        logic [7:0] v;

        vt[0] = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'hFF, 8'd0, 1'b1, 1'b1, 8'd0, 8'hA5};
        vt[1] = '{8'h5A, 8'h0F, 8'h00, 8'h55, 8'hFF, 8'd0, 1'b1, 1'b1, 8'd0, 8'h55};
        vt[2] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0F, 8'd0, 1'b1, 1'b0, 8'd1, 8'h01};
        vt[3] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hF0, 8'd0, 1'b1, 1'b1, 8'd0, 8'h01};
        vt[4] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'd0, 1'b0, 1'b1, 8'd0, 8'hFF};
        vt[5] = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h80, 8'd2, 1'b1, 1'b1, 8'd0, 8'hFF};
        vt[6] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h80, 8'd1, 1'b1, 1'b0, 8'd1, 8'h80};

        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; abort = 1'b0; cap_addr = '0; uo_xor = 8'h00;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_pass", {31'd0, pass}, 0);
        chk("rst_cnt", {24'd0, mismatch_cnt}, 0);
        chk("rst_ff", {23'd0, first_fail}, 0);
        chk("rst_ui", {24'd0, dut_ui_in}, 0);
        chk("rst_uio", {24'd0, dut_uio_in}, 0);
        chk("rst_dut_rst", {31'd0, dut_rst_n}, 0);
        chk("rst_ena", {31'd0, dut_ena}, 0);
        chk("rst_cap", {24'd0, cap_data}, 0);
        rst_n = 1'b1;
        tick();

        // Abort while idle does nothing.
        abort = 1'b1; tick(); abort = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 0);
        chk("idle_abort_done", {31'd0, done}, 0);

        // Table of single-entry runs.
        for (int i = 0; i < 7; i++) begin
            load(0, mk_entry(1'b1, vt[i].chk_en, vt[i].hold, vt[i].mask, vt[i].ex, vt[i].uio, vt[i].ui));
            uo_xor = vt[i].xr;
            launch(1);
            wait_done(cyc);
            chk($sformatf("tbl%0d_pass", i), {31'd0, pass}, {31'd0, vt[i].exp_pass});
            chk($sformatf("tbl%0d_cnt", i), {24'd0, mismatch_cnt}, {24'd0, vt[i].exp_cnt});
            chk($sformatf("tbl%0d_ff", i), {23'd0, first_fail}, 0);
            chk($sformatf("tbl%0d_lat", i), cyc, 32'(vt[i].hold) + 2);
            chk($sformatf("tbl%0d_ena", i), {31'd0, dut_ena}, 0);
            chk($sformatf("tbl%0d_drst", i), {31'd0, dut_rst_n}, 0);
            chk($sformatf("tbl%0d_ui_held", i), {24'd0, dut_ui_in}, {24'd0, vt[i].ui});
            read_cap(0, v);
            chk($sformatf("tbl%0d_cap", i), {24'd0, v}, {24'd0, vt[i].exp_cap});
        end
        uo_xor = 8'h00;

        // Pins appear on the second cycle after start.
        load(0, mk_entry(1'b1, 1'b1, 8'd0, 8'hFF, 8'hA5, 8'h00, 8'hA5));
        launch(1);
        chk("seq_pins_fetch", {24'd0, dut_ui_in}, 32'h00);
        chk("seq_busy", {31'd0, busy}, 1);
        chk("seq_ena", {31'd0, dut_ena}, 1);
        tick();
        chk("seq_pins_apply", {24'd0, dut_ui_in}, 32'hA5);
        chk("seq_drst_apply", {31'd0, dut_rst_n}, 1);
        tick();
        chk("seq_done", {31'd0, done}, 1);
        chk("seq_pass", {31'd0, pass}, 1);

        // Three entries, middle one fails its masked check.
        load(0, mk_entry(1'b1, 1'b1, 8'd0, 8'hFF, 8'h11, 8'h00, 8'h11));
        load(1, mk_entry(1'b1, 1'b1, 8'd0, 8'h0F, 8'h00, 8'h00, 8'h01));
        load(2, mk_entry(1'b1, 1'b1, 8'd0, 8'hFF, 8'h22, 8'h00, 8'h22));
        launch(3);
        wait_done(cyc);
        chk("three_cnt", {24'd0, mismatch_cnt}, 1);
        chk("three_ff", {23'd0, first_fail}, 1);
        chk("three_pass", {31'd0, pass}, 0);
        chk("three_lat", cyc, 6);

        // hold=4: pins stable five cycles, sample only on the fifth.
        load(0, mk_entry(1'b1, 1'b1, 8'd4, 8'hFF, 8'h3C, 8'h00, 8'h3C));
        launch(1);
        uo_xor = 8'hFF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("hold_pin_c%0d", c), {24'd0, dut_ui_in}, 32'h3C);
            chk($sformatf("hold_busy_c%0d", c), {31'd0, busy}, 1);
        end
        tick();
        chk("hold_busy_c5", {31'd0, busy}, 1);
        chk("hold_pin_c5", {24'd0, dut_ui_in}, 32'h3C);
        uo_xor = 8'h00;
        tick();
        chk("hold_done", {31'd0, done}, 1);
        chk("hold_pass", {31'd0, pass}, 1);
        read_cap(0, v);
        chk("hold_cap", {24'd0, v}, 32'h3C);

        // Saturation: 5 passing entries then 300 failing ones.
        for (int i = 0; i < 305; i++) begin
            logic [7:0] u;
            u = 8'(i);
            load(i, mk_entry(1'b1, 1'b1, 8'd0, 8'hFF, (i < 5) ? u : ~u, 8'h00, u));
        end
        launch(305);
        wait_done(cyc);
        chk("sat_cnt", {24'd0, mismatch_cnt}, 255);
        chk("sat_ff", {23'd0, first_fail}, 5);
        chk("sat_pass", {31'd0, pass}, 0);
        chk("sat_lat", cyc, 610);

        // Empty program: done and pass on the next cycle, pins untouched.
        launch(0);
        chk("empty_done", {31'd0, done}, 1);
        chk("empty_pass", {31'd0, pass}, 1);
        chk("empty_cnt", {24'd0, mismatch_cnt}, 0);
        chk("empty_ff", {23'd0, first_fail}, 0);
        chk("empty_busy", {31'd0, busy}, 0);
        chk("empty_ena", {31'd0, dut_ena}, 0);
        chk("empty_ui", {24'd0, dut_ui_in}, 32'h30);

        // Start and prog_we while busy are ignored.
        for (int i = 0; i < 3; i++)
            load(i, mk_entry(1'b1, 1'b1, 8'd2, 8'hFF, 8'h40 + 8'(i), 8'h00, 8'h40 + 8'(i)));
        launch(3);
        tick();
        start = 1'b1; prog_len = 10'd1;
        prog_we = 1'b1; prog_addr = 9'd2; prog_data = mk_entry(1'b1, 1'b1, 8'd0, 8'hFF, 8'hBD, 8'h00, 8'h42);
        tick();
        start = 1'b0; prog_we = 1'b0;
        wait_done(cyc);
        chk("busy_lat", cyc + 2, 12);
        chk("busy_pass", {31'd0, pass}, 1);
        read_cap(2, v);
        chk("busy_cap2", {24'd0, v}, 32'h42);
        launch(3);
        wait_done(cyc);
        chk("busy_rerun_pass", {31'd0, pass}, 1);

        // Abort together with start in DONE: abort wins, nothing runs.
        abort = 1'b1; start = 1'b1; prog_len = 10'd3;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abst_busy", {31'd0, busy}, 0);
        chk("abst_done", {31'd0, done}, 1);
        tick();
        chk("abst_busy2", {31'd0, busy}, 0);

        // Abort in the hold phase of entry 2 of 5.
        for (int i = 0; i < 5; i++)
            load(i, mk_entry(1'b1, 1'b1, 8'd3, 8'hFF, 8'h50 + 8'(i), 8'h00, 8'h50 + 8'(i)));
        launch(5);
        k = 0;
        while (dut_ui_in !== 8'h52 && k < 100) begin
            tick();
            k++;
        end
        chk("abort_reach", {24'd0, dut_ui_in}, 32'h52);
        tick();
        chk("abort_pre_busy", {31'd0, busy}, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", {31'd0, done}, 1);
        chk("abort_pass", {31'd0, pass}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_ena", {31'd0, dut_ena}, 0);
        chk("abort_drst", {31'd0, dut_rst_n}, 0);
        chk("abort_ui", {24'd0, dut_ui_in}, 32'h52);
        tick();
        chk("abort_stays", {31'd0, busy}, 0);

        // Randomized programs against a reference model.
        for (int r = 0; r < 10; r++) begin
            int len, nfail, ffirst, lat;
            logic [7:0] last_ui, last_uio;
            len = $urandom_range(1, 12);
            nfail = 0; ffirst = -1; lat = 0;
            last_ui = 0; last_uio = 0;
            for (int i = 0; i < len; i++) begin
                logic [7:0] ui, uio, ex, m, h, capv;
                logic c, rb;
                ui  = 8'($urandom); uio = 8'($urandom);
                m   = 8'($urandom); h = 8'($urandom_range(0, 3));
                c   = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
                capv = ui ^ uio;
                ex  = ($urandom_range(0, 1) == 1) ? capv : 8'($urandom);
                if (c && ((capv ^ ex) & m) != 8'h00) begin
                    nfail++;
                    if (ffirst < 0) ffirst = i;
                end
                lat += int'(h) + 2;
                exp_q.push_back(capv);
                last_ui = ui; last_uio = uio;
                load(i, mk_entry(rb, c, h, m, ex, uio, ui));
            end
            launch(len);
            wait_done(cyc);
            chk($sformatf("rnd%0d_pass", r), {31'd0, pass}, (nfail == 0) ? 1 : 0);
            chk($sformatf("rnd%0d_cnt", r), {24'd0, mismatch_cnt}, nfail);
            chk($sformatf("rnd%0d_ff", r), {23'd0, first_fail}, (ffirst < 0) ? 0 : ffirst);
            chk($sformatf("rnd%0d_lat", r), cyc, lat);
            chk($sformatf("rnd%0d_ui", r), {24'd0, dut_ui_in}, {24'd0, last_ui});
            chk($sformatf("rnd%0d_uio", r), {24'd0, dut_uio_in}, {24'd0, last_uio});
            chk($sformatf("rnd%0d_drst", r), {31'd0, dut_rst_n}, 0);
            for (int i = 0; i < len; i++) begin
                logic [7:0] expc;
                expc = exp_q.pop_front();
                read_cap(i, v);
                chk($sformatf("rnd%0d_cap%0d", r, i), {24'd0, v}, {24'd0, expc});
            end
        end

        // Asynchronous reset in the middle of a run.
        load(0, mk_entry(1'b1, 1'b0, 8'd10, 8'h00, 8'h00, 8'h00, 8'h77));
        load(1, mk_entry(1'b1, 1'b0, 8'd10, 8'h00, 8'h00, 8'h00, 8'h78));
        launch(2);
        tick(); tick(); tick();
        chk("arst_pre_drst", {31'd0, dut_rst_n}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_drst", {31'd0, dut_rst_n}, 0);
        chk("arst_ena", {31'd0, dut_ena}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_ui", {24'd0, dut_ui_in}, 0);
        chk("arst_cap", {24'd0, cap_data}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle_done", {31'd0, done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
